fetch_ctrl: RTL and testbench

- Sequences the program counter and the instruction-memory fetch handshake for the core front end.
- Owns the fetch PC register and issues one outstanding word request at a time.
- Applies branch/jump redirects from execute, including redirects that arrive while a fetch is in flight.
- Presents fetched instructions to decode through a valid/ready handshake.

---
 rtl/fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end program counter sequencer and instruction-memory
// fetch handshake. One outstanding word request at a time; branch/jump
// redirects from execute are honoured in FETCH and HOLD, including while a
// request is in flight (the in-flight word is killed when it returns).
// Optional build macro FETCH_STALL_CNT_EN adds a saturating stall_cnt output
// counting FETCH cycles without an imem_ack.
module fetch_ctrl #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              do_branch,
    input  logic [ADDR_W-1:0] branch_address,
    input  logic              do_jump,
    input  logic [ADDR_W-1:0] jump_address,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] pc,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              flush
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              flush_q, flush_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              redir;
    logic [ADDR_W-1:0] target;

    // Branch beats jump when both arrive together.
    always_comb begin
        redir  = do_branch | do_jump;
        target = do_branch ? branch_address : jump_address;
    end

    // Next-state, datapath updates and the request strobe.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        flush_d      = 1'b0;
        kill_d       = kill_q;
        pend_d       = pend_q;
        imem_req     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (redir) begin
                    flush_d = 1'b1;
                    if (imem_ack) begin
                        // Returning word is stale; jump straight to the target.
                        pc_d   = target;
                        kill_d = 1'b0;
                    end else begin
                        // Keep the address stable for memory; retarget on ack.
                        kill_d = 1'b1;
                        pend_d = target;
                    end
                end else if (imem_ack) begin
                    if (kill_q) begin
                        pc_d   = pend_q;
                        kill_d = 1'b0;
                    end else begin
                        inst_d       = imem_data;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + ADDR_W'(1);
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redir) begin
                    flush_d      = 1'b1;
                    inst_valid_d = 1'b0;
                    pc_d         = target;
                    state_d      = FETCH;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            flush_q      <= 1'b0;
            kill_q       <= 1'b0;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            flush_q      <= flush_d;
            kill_q       <= kill_d;
            pend_q       <= pend_d;
        end
    end

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign flush      = flush_q;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count FETCH cycles waiting on memory, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == FETCH && !imem_ack && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl (RESET_PC = 0x10). Inputs change 1 time
// unit after each rising edge; outputs are checked at the same point.
module tb_fetch_ctrl;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              do_branch;
    logic [ADDR_W-1:0] branch_address;
    logic              do_jump;
    logic [ADDR_W-1:0] jump_address;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_data;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic [ADDR_W-1:0] pc;
    logic              flush;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fetch_ctrl #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(32'h10)) dut (
        .clk(clk), .rst(rst),
        .do_branch(do_branch), .branch_address(branch_address),
        .do_jump(do_jump), .jump_address(jump_address),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .pc(pc),
`ifdef FETCH_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; do_branch = 1'b0; do_jump = 1'b0;
        branch_address = '0; jump_address = '0;
        imem_ack = 1'b0; imem_data = '0; inst_ready = 1'b1;
        tick(); tick();
        n_tests++; if (pc !== 32'h10)     begin n_fail++; $display("FAIL rst_pc got %h want 00000010", pc); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", imem_req); end
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", inst_valid); end
        n_tests++; if (inst !== 32'h0)    begin n_fail++; $display("FAIL rst_inst got %h want 0", inst); end
        n_tests++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst_pc got %h want 0", inst_pc); end
        n_tests++; if (flush !== 1'b0)    begin n_fail++; $display("FAIL rst_flush got %b want 0", flush); end
        // Release reset; a stray ack during IDLE must be ignored.
        rst = 1'b0; imem_ack = 1'b1; imem_data = 32'hDEAD_DEAD;
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b want 0", imem_req); end
        tick();
        n_tests++; if (inst_valid !== 1'b0 || pc !== 32'h10 || imem_req !== 1'b1)
            begin n_fail++; $display("FAIL idle_ack_ignored valid=%b pc=%h req=%b want 0 00000010 1", inst_valid, pc, imem_req); end
    endtask

    // Zero-wait memory, decode always ready: one instruction every 2 cycles.
    task automatic test_stream();
        logic [31:0] a;
        for (int k = 0; k < 6; k++) begin
            a = 32'h10 + 32'(k / 2);
            if (k % 2 == 0) begin
                n_tests++; if (imem_req !== 1'b1 || imem_addr !== a || inst_valid !== 1'b0)
                    begin n_fail++; $display("FAIL stream_req k=%0d req=%b addr=%h valid=%b want 1 %h 0", k, imem_req, imem_addr, inst_valid, a); end
                imem_ack = 1'b1; imem_data = 32'hA000_0000 | a;
            end else begin
                n_tests++; if (inst_valid !== 1'b1 || inst_pc !== a || inst !== (32'hA000_0000 | a) || imem_req !== 1'b0)
                    begin n_fail++; $display("FAIL stream_inst k=%0d valid=%b pc=%h inst=%h req=%b want 1 %h %h 0", k, inst_valid, inst_pc, inst, imem_req, a, 32'hA000_0000 | a); end
                imem_ack = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_ready_stall();
        imem_ack = 1'b1; imem_data = 32'hA000_0013; inst_ready = 1'b0;
        tick();
        imem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (inst_valid !== 1'b1 || inst !== 32'hA000_0013 || inst_pc !== 32'h13 || imem_req !== 1'b0)
                begin n_fail++; $display("FAIL stall_hold k=%0d valid=%b inst=%h pc=%h req=%b want 1 a0000013 00000013 0", k, inst_valid, inst, inst_pc, imem_req); end
            tick();
        end
        inst_ready = 1'b1;
        tick();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h14 || inst_valid !== 1'b0)
            begin n_fail++; $display("FAIL stall_resume req=%b addr=%h valid=%b want 1 00000014 0", imem_req, imem_addr, inst_valid); end
    endtask

    // Branch while the request to 0x14 is outstanding; ack arrives later.
    task automatic test_branch_in_fetch();
        int flushes = 0;
        do_branch = 1'b1; branch_address = 32'h40;
        tick();
        do_branch = 1'b0;
        for (int k = 0; k < 3; k++) begin
            flushes += int'(flush);
            n_tests++; if (imem_addr !== 32'h14 || imem_req !== 1'b1)
                begin n_fail++; $display("FAIL kill_addr_stable k=%0d addr=%h req=%b want 00000014 1", k, imem_addr, imem_req); end
            if (k == 2) begin imem_ack = 1'b1; imem_data = 32'hBAD0_0000; end
            tick();
        end
        flushes += int'(flush);
        imem_ack = 1'b0;
        n_tests++; if (imem_addr !== 32'h40 || inst_valid !== 1'b0 || imem_req !== 1'b1)
            begin n_fail++; $display("FAIL kill_retarget addr=%h valid=%b req=%b want 00000040 0 1", imem_addr, inst_valid, imem_req); end
        n_tests++; if (flushes != 1)
            begin n_fail++; $display("FAIL kill_flush_count got %0d want 1", flushes); end
        imem_ack = 1'b1; imem_data = 32'hA000_0040;
        tick();
        imem_ack = 1'b0;
        n_tests++; if (inst_valid !== 1'b1 || inst !== 32'hA000_0040 || inst_pc !== 32'h40)
            begin n_fail++; $display("FAIL kill_next_inst valid=%b inst=%h pc=%h want 1 a0000040 00000040", inst_valid, inst, inst_pc); end
        tick();
    endtask

    // Branch and jump together in HOLD: branch wins, instruction dropped.
    task automatic test_redirect_hold();
        imem_ack = 1'b1; imem_data = 32'hA000_0041; inst_ready = 1'b0;
        tick();
        imem_ack = 1'b0;
        n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h41)
            begin n_fail++; $display("FAIL hold_setup valid=%b pc=%h want 1 00000041", inst_valid, inst_pc); end
        do_branch = 1'b1; branch_address = 32'h40;
        do_jump = 1'b1; jump_address = 32'h80; inst_ready = 1'b1;
        tick();
        do_branch = 1'b0; do_jump = 1'b0;
        n_tests++; if (inst_valid !== 1'b0 || imem_addr !== 32'h40 || flush !== 1'b1 || imem_req !== 1'b1)
            begin n_fail++; $display("FAIL hold_redirect valid=%b addr=%h flush=%b req=%b want 0 00000040 1 1", inst_valid, imem_addr, flush, imem_req); end
    endtask

    // Jump with same-cycle ack to all-ones, then fetch it so pc wraps.
    task automatic test_wrap();
        do_jump = 1'b1; jump_address = 32'hFFFF_FFFF;
        imem_ack = 1'b1; imem_data = 32'hBAD0_0001;
        tick();
        do_jump = 1'b0;
        n_tests++; if (imem_addr !== 32'hFFFF_FFFF || inst_valid !== 1'b0 || imem_req !== 1'b1)
            begin n_fail++; $display("FAIL wrap_jump addr=%h valid=%b req=%b want ffffffff 0 1", imem_addr, inst_valid, imem_req); end
        imem_data = 32'hA000_00FF;
        tick();
        imem_ack = 1'b0;
        n_tests++; if (pc !== 32'h0 || inst_pc !== 32'hFFFF_FFFF || inst !== 32'hA000_00FF || inst_valid !== 1'b1)
            begin n_fail++; $display("FAIL wrap_pc pc=%h inst_pc=%h inst=%h valid=%b want 0 ffffffff a00000ff 1", pc, inst_pc, inst, inst_valid); end
        tick();
        n_tests++; if (imem_addr !== 32'h0 || imem_req !== 1'b1)
            begin n_fail++; $display("FAIL wrap_fetch addr=%h req=%b want 0 1", imem_addr, imem_req); end
    endtask

    // Asynchronous reset during FETCH, then a stray ack in IDLE.
    task automatic test_reset_midfetch();
        rst = 1'b1;
        #1;
        n_tests++; if (pc !== 32'h10 || imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 || flush !== 1'b0)
            begin n_fail++; $display("FAIL midrst_async pc=%h req=%b valid=%b inst=%h ipc=%h flush=%b want 00000010 0 0 0 0 0", pc, imem_req, inst_valid, inst, inst_pc, flush); end
        tick();
        rst = 1'b0; imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        n_tests++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10)
            begin n_fail++; $display("FAIL midrst_stray valid=%b req=%b addr=%h want 0 1 00000010", inst_valid, imem_req, imem_addr); end
        imem_ack = 1'b1; imem_data = 32'hA000_0010;
        tick();
        imem_ack = 1'b0;
        n_tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst !== 32'hA000_0010)
            begin n_fail++; $display("FAIL midrst_restart valid=%b pc=%h inst=%h want 1 00000010 a0000010", inst_valid, inst_pc, inst); end
        tick();
    endtask

`ifdef FETCH_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst = 1'b1; imem_ack = 1'b0; inst_ready = 1'b1;
        #1;
        n_tests++; if (stall_cnt !== 32'd0)
            begin n_fail++; $display("FAIL stallcnt_rst got %0d want 0", stall_cnt); end
        tick();
        rst = 1'b0;
        tick();
        for (int f = 0; f < 3; f++) begin
            repeat (4) tick();
            imem_ack = 1'b1; imem_data = 32'h1;
            tick();
            imem_ack = 1'b0;
            tick();
        end
        n_tests++; if (stall_cnt !== 32'd12)
            begin n_fail++; $display("FAIL stallcnt_value got %0d want 12", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_ready_stall();
        test_branch_in_fetch();
        test_redirect_hold();
        test_wrap();
        test_reset_midfetch();
`ifdef FETCH_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
